// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock-qualification sequencer owning the core reset release.
// Optional build macro PLL_LOSS_FILTER_EN: debounce loss-of-lock while in RUN.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES         = 16,
  parameter int unsigned TIMEOUT_CYCLES     = 742500,
  parameter int unsigned STABLE_CYCLES      = 1024,
  parameter int unsigned MAX_RETRIES        = 7,
  parameter int unsigned LOSS_FILTER_CYCLES = 4
) (
  input  logic                               clk_74a,
  input  logic                               reset_n,
  input  logic                               pll_locked,
  input  logic                               relock_req,
  output logic                               relock_ack,
  output logic                               pll_rst,
  output logic                               core_reset_n,
  output logic                               ready,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [2:0]                         state
);

  localparam int unsigned RW      = $clog2(MAX_RETRIES + 1);
  localparam int unsigned CNT_MAX =
    (TIMEOUT_CYCLES > RST_CYCLES) ?
      ((TIMEOUT_CYCLES > STABLE_CYCLES) ? TIMEOUT_CYCLES : STABLE_CYCLES) :
      ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  if (RST_CYCLES < 1 || TIMEOUT_CYCLES < 1 || STABLE_CYCLES < 1 ||
      LOSS_FILTER_CYCLES < 1) begin : g_param_check
    $error("pll_lock_sequencer: cycle parameters must be at least 1");
  end

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [RW-1:0]   r_retry, w_retry_nxt;
  logic            r_sync1, r_sync2;
  logic            w_ack_nxt;
  logic            w_loss;
  logic            r_pll_rst, r_core_reset_n, r_ready, r_fail, r_ack;

  // pll_locked is asynchronous to the reference clock
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PLL_LOSS_FILTER_EN
  localparam int unsigned LW = $clog2(LOSS_FILTER_CYCLES + 1);
  logic [LW-1:0] r_loss_cnt, w_loss_cnt_nxt;

  always_comb begin
    w_loss         = 1'b0;
    w_loss_cnt_nxt = '0;
    if (r_state == S_RUN && !r_sync2) begin
      if (r_loss_cnt == LW'(LOSS_FILTER_CYCLES - 1))
        w_loss = 1'b1;
      else
        w_loss_cnt_nxt = r_loss_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) r_loss_cnt <= '0;
    else          r_loss_cnt <= w_loss_cnt_nxt;
  end
`else
  assign w_loss = ~r_sync2;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_ack_nxt   = 1'b0;
    case (r_state)
      S_RESET: begin
        if (r_cnt == CW'(RST_CYCLES - 1)) w_state_nxt = S_WAIT;
        else                              w_cnt_nxt   = r_cnt + 1'b1;
      end
      S_WAIT: begin
        if (r_sync2) begin
          w_state_nxt = S_STABLE;
        end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          if (r_retry == RW'(MAX_RETRIES)) begin
            w_state_nxt = S_FAIL;
          end else begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = S_RESET;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STABLE: begin
        if (!r_sync2)                            w_state_nxt = S_WAIT;
        else if (r_cnt == CW'(STABLE_CYCLES - 1)) w_state_nxt = S_RUN;
        else                                     w_cnt_nxt   = r_cnt + 1'b1;
      end
      S_RUN: begin
        // a request coinciding with a loss still gets its ack; one transition only
        if (relock_req) begin
          w_ack_nxt   = 1'b1;
          w_retry_nxt = '0;
          w_state_nxt = S_RESET;
        end else if (w_loss) begin
          w_retry_nxt = '0;
          w_state_nxt = S_RESET;
        end
      end
      S_FAIL: begin
        if (relock_req) begin
          w_ack_nxt   = 1'b1;
          w_retry_nxt = '0;
          w_state_nxt = S_RESET;
        end
      end
      default: w_state_nxt = S_RESET;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_RESET;
      r_cnt          <= '0;
      r_retry        <= '0;
      r_pll_rst      <= 1'b1;
      r_core_reset_n <= 1'b0;
      r_ready        <= 1'b0;
      r_fail         <= 1'b0;
      r_ack          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_retry        <= w_retry_nxt;
      r_pll_rst      <= (w_state_nxt == S_RESET) || (w_state_nxt == S_FAIL);
      r_core_reset_n <= (w_state_nxt == S_RUN);
      r_ready        <= (w_state_nxt == S_RUN);
      r_fail         <= (w_state_nxt == S_FAIL);
      r_ack          <= w_ack_nxt;
    end
  end

  assign relock_ack   = r_ack;
  assign pll_rst      = r_pll_rst;
  assign core_reset_n = r_core_reset_n;
  assign ready        = r_ready;
  assign fail         = r_fail;
  assign retry_cnt    = r_retry;
  assign state        = r_state;

endmodule
